// File: rtl/fp16_mul_sched.sv
`default_nettype none
// ============================================================================
//  Module   : fp16_mul_sched
//  Purpose  : Round-robin scheduler that shares one FP16 log-multiplier core
//             between up to four requesters. A request is accepted in IDLE,
//             launched on the core (ISSUE), the core result is awaited (WAIT),
//             and the product is offered on a valid/ready response port (RESP).
//  Ports    :
//    clk, rst_n             clock, asynchronous active-low reset
//    req_valid/req_ready    per-requester request handshake (ready is one-hot)
//    req_a/req_b            packed FP16 operands, slice i = [16i+15:16i]
//    core_start             one-cycle launch pulse to the shared core
//    core_a/core_b          operands to the core, held from launch to done
//    core_done/core_result  one-cycle completion pulse and product from core
//    rsp_valid/rsp_ready    response handshake
//    rsp_id/rsp_data        owner index and FP16 product of the response
//    busy                   high whenever the FSM is not in IDLE
//    op_count               completed responses, wraps 255 -> 0
//  Config   : define FP16_SCHED_ZERO_BYPASS_EN to answer multiplications with a
//             (signed) zero operand directly, without using the core.
//  Revision : 1.0 - initial release
// ============================================================================
module fp16_mul_sched #(
    parameter int NREQ         = 4,
    parameter int RR_RESET_PTR = NREQ - 1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [NREQ-1:0]      req_valid,
    input  logic [16*NREQ-1:0]   req_a,
    input  logic [16*NREQ-1:0]   req_b,
    output logic [NREQ-1:0]      req_ready,
    output logic                 core_start,
    output logic [15:0]          core_a,
    output logic [15:0]          core_b,
    input  logic                 core_done,
    input  logic [15:0]          core_result,
    output logic                 rsp_valid,
    input  logic                 rsp_ready,
    output logic [1:0]           rsp_id,
    output logic [15:0]          rsp_data,
    output logic                 busy,
    output logic [7:0]           op_count
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        RESP  = 2'd3
    } state_t;

    state_t            state;
    state_t            state_nxt;
    logic [1:0]        last_grant;

    logic              grant_found;
    logic [1:0]        grant_idx;
    logic [1:0]        cand;
    logic [NREQ-1:0]   grant_onehot;
    logic [15:0]       sel_a;
    logic [15:0]       sel_b;
    logic              zero_hit;

    // ------------------------------------------------------------------------
    // Round-robin search: start one past the last winner and wrap, so the
    // last winner is the lowest-priority candidate this round.
    // ------------------------------------------------------------------------
    always_comb begin
        grant_found = 1'b0;
        grant_idx   = 2'd0;
        cand        = 2'd0;
        for (int k = 1; k <= NREQ; k++) begin
            cand = 2'((int'(last_grant) + k) % NREQ);
            if (!grant_found && req_valid[cand]) begin
                grant_found = 1'b1;
                grant_idx   = cand;
            end
        end
    end

    // Operand selection and one-hot form of the winning index.
    always_comb begin
        sel_a        = 16'd0;
        sel_b        = 16'd0;
        grant_onehot = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (grant_idx == 2'(i)) begin
                sel_a           = req_a[16*i +: 16];
                sel_b           = req_b[16*i +: 16];
                grant_onehot[i] = 1'b1;
            end
        end
    end

`ifdef FP16_SCHED_ZERO_BYPASS_EN
    // Magnitude bits all clear means +0 or -0; the product is then a zero
    // whose sign is the XOR of the operand signs.
    assign zero_hit = (sel_a[14:0] == 15'd0) || (sel_b[14:0] == 15'd0);
`else
    assign zero_hit = 1'b0;
`endif

    // ------------------------------------------------------------------------
    // Next-state and output decode
    // ------------------------------------------------------------------------
    always_comb begin
        state_nxt  = state;
        req_ready  = '0;
        core_start = 1'b0;
        rsp_valid  = 1'b0;
        busy       = (state != IDLE);
        case (state)
            IDLE: begin
                // Gate with rst_n so no acceptance is signalled while the
                // block is held in reset (state is IDLE during reset).
                if (grant_found && rst_n) begin
                    req_ready = grant_onehot;
                    state_nxt = zero_hit ? RESP : ISSUE;
                end
            end
            ISSUE: begin
                core_start = 1'b1;
                state_nxt  = WAIT;
            end
            WAIT: begin
                if (core_done) begin
                    state_nxt = RESP;
                end
            end
            RESP: begin
                rsp_valid = 1'b1;
                if (rsp_ready) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // ------------------------------------------------------------------------
    // State and datapath registers
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            last_grant <= 2'(RR_RESET_PTR);
            core_a     <= 16'd0;
            core_b     <= 16'd0;
            rsp_id     <= 2'd0;
            rsp_data   <= 16'd0;
            op_count   <= 8'd0;
        end else begin
            state <= state_nxt;
            case (state)
                IDLE: begin
                    if (grant_found) begin
                        last_grant <= grant_idx;
                        rsp_id     <= grant_idx;
                        core_a     <= sel_a;
                        core_b     <= sel_b;
                        if (zero_hit) begin
                            rsp_data <= {sel_a[15] ^ sel_b[15], 15'd0};
                        end
                    end
                end
                // core_done outside WAIT (including a late pulse after a
                // reset abort) is not looked at anywhere else.
                WAIT: begin
                    if (core_done) begin
                        rsp_data <= core_result;
                    end
                end
                RESP: begin
                    if (rsp_ready) begin
                        op_count <= op_count + 8'd1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: doc/fp16_mul_sched.md
FP16_MUL_SCHED -- requirements
Module: fp16_mul_sched

Interface
REQ-001 Parameter NREQ, default 4: number of requesters; legal values 2..4; ID fields are 2 bits wide.
REQ-002 Parameter RR_RESET_PTR, default NREQ-1: last-grant pointer value after reset, so requester 0 wins first.
REQ-003 clk  in  1  single clock; all state changes on its rising edge.
REQ-004 rst_n  in  1  asynchronous, active-low reset.
REQ-005 req_valid  in  NREQ  per-requester operation request.
REQ-006 req_a  in  16*NREQ  FP16 operand A per requester; slice i = bits [16i+15:16i].
REQ-007 req_b  in  16*NREQ  FP16 operand B per requester, same slicing.
REQ-008 req_ready  out  NREQ  one-hot acceptance pulse; the request is taken when req_valid[i] & req_ready[i].
REQ-009 core_start  out  1  one-cycle launch pulse to the shared FP16 log multiplier core.
REQ-010 core_a / core_b  out  16 each  operands to the core; held stable from core_start until core_done.
REQ-011 core_done  in  1  one-cycle completion pulse from the core.
REQ-012 core_result  in  16  core product, valid in the core_done cycle.
REQ-013 rsp_valid  out  1  response available.
REQ-014 rsp_ready  in  1  consumer accepts the response.
REQ-015 rsp_id  out  2  index of the requester that owns rsp_data.
REQ-016 rsp_data  out  16  FP16 product.
REQ-017 busy  out  1  high in every state except IDLE.
REQ-018 op_count  out  8  count of completed responses; wraps 255 -> 0.

Function
REQ-019 The FSM SHALL have the states IDLE, ISSUE, WAIT and RESP.
REQ-020 IDLE: when any req_valid is high, the block SHALL grant the first valid index searching upward from (last_grant+1) mod NREQ.
  - In the same cycle: assert req_ready[g] combinationally.
  - On the edge: latch req_a[g], req_b[g] and g; set last_grant to g; go to ISSUE.
REQ-021 req_ready SHALL be low in every state other than IDLE, so at most one bit is high in any cycle.
REQ-022 ISSUE: core_start SHALL be high for exactly one cycle with the latched operands on core_a/core_b; the next state is WAIT.
REQ-023 WAIT: on core_done the block SHALL capture core_result into rsp_data and go to RESP; core_done in any other state SHALL be ignored.
REQ-024 RESP: rsp_valid, rsp_id and rsp_data SHALL stay stable while rsp_ready is low.
  - On rsp_valid & rsp_ready: increment op_count and go to IDLE.
REQ-025 Timing: accept at cycle T gives core_start at T+1; core_done at T+1+L gives rsp_valid at T+2+L; the earliest next grant is the cycle after the rsp handshake.
REQ-026 Requests that are not granted SHALL remain pending with no loss; a requester deasserting req_valid before its grant is legal.
REQ-027 Fairness: with all requesters continuously valid, grants SHALL rotate 0,1,..,NREQ-1,0.
REQ-028 core_a/core_b SHALL hold the last latched operands outside ISSUE/WAIT; core_start SHALL be 0 except in ISSUE.

Reset
REQ-029 Asserting rst_n low at any time, including mid-WAIT or mid-RESP, SHALL immediately force:
  - state IDLE;
  - req_ready, core_start, rsp_valid and busy all 0;
  - core_a, core_b, rsp_data, rsp_id and op_count all 0;
  - last_grant = RR_RESET_PTR.
REQ-030 A core_done that arrives after a reset abort SHALL be ignored.

Configuration
REQ-031 Macro FP16_SCHED_ZERO_BYPASS_EN, when defined, enables the zero bypass.
  - Condition: at grant, bits[14:0] of either operand are 0.
  - Action: the FSM goes IDLE -> RESP directly, core_start is not asserted, and rsp_data is set to {a[15]^b[15], 15'b0}.
  - Timing: rsp_valid at T+1.
REQ-032 Without FP16_SCHED_ZERO_BYPASS_EN, every granted operation SHALL pass through ISSUE/WAIT, zero operands included.

Verification
REQ-033 Single request: req 0 a=0x3C00, b=0x4000; core model returns 0x4000 with L=6.
  - Required: one core_start carrying 0x3C00/0x4000.
  - Required: rsp_valid at T+8 with rsp_id=0, rsp_data=0x4000; op_count=1.
REQ-034 All four requesters valid continuously for 8 operations -> rsp_id sequence 0,1,2,3,0,1,2,3, with exactly one req_ready per grant.
REQ-035 Backpressure: rsp_ready held low 10 cycles -> rsp_valid/rsp_data stable throughout, no new core_start, no req_ready.
REQ-036 Reset mid-WAIT: rst_n low for 2 cycles, then core_done pulses.
  - Required: all outputs 0 and state IDLE.
  - Required: no rsp_valid; the next grant goes to requester 0.
REQ-037 Zero bypass: a=0x8000, b=0x4200.
  - With the macro: rsp_data=0x8000 at T+1 and no core_start.
  - Without the macro: the core path is used and the core result is forwarded.
REQ-038 op_count wrap: 256 completed operations -> op_count reads 0.
